// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage MIPS pipeline control logic.
//   - FWD_* : select codes for the EX operand muxes
//             (0 = register file, 1 = EX-MEM result, 2 = MEM-WB result)
//   - stage_rec_t : per-stage tracking record {rd, we, load}
//   - src_hit / fwd_select : hazard compare and forwarding priority,
//             shared by the rs and rt paths
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic [PIPE_REG_W-1:0] rd;
        logic                  we;
        logic                  load;
    } stage_rec_t;

    localparam stage_rec_t STAGE_EMPTY = '0;

    // A source hits a stage record when it is really read, the stage really
    // writes, and the indices match. $0 is hard-wired, so it never hits.
    function automatic logic src_hit(
        input stage_rec_t            rec,
        input logic [PIPE_REG_W-1:0] src,
        input logic                  use_src
    );
        return use_src && rec.we && (rec.rd == src) && (rec.rd != '0);
    endfunction

    // Forwarding select for one source. The younger producer (ex) wins.
    // A load sitting in ex cannot forward yet; that case is a load-use
    // stall and the bubble clears the select anyway, so fall through.
    function automatic logic [1:0] fwd_select(
        input stage_rec_t            ex,
        input stage_rec_t            mem,
        input logic [PIPE_REG_W-1:0] src,
        input logic                  use_src
    );
        if (src_hit(ex, src, use_src) && !ex.load) begin
            return FWD_EXMEM;
        end else if (src_hit(mem, src, use_src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_track_stage.sv
// ---------------------------------------------------------------------------
// fwd_track_stage
// One pipeline-stage tracking record with asynchronous active-low reset.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : load enable (deasserted during a global hold)
//   clr        : when loading, store an empty record instead of d (bubble)
//   d          : incoming record from the previous stage
//   q          : current record
// ---------------------------------------------------------------------------
module fwd_track_stage
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  stage_rec_t d,
    output stage_rec_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= STAGE_EMPTY;
        end else if (en) begin
            q <= clr ? STAGE_EMPTY : d;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_ctrl
// Operand-forwarding and load-use hazard controller. Tracks the destination
// of the instructions in EX, MEM and WB and compares them with the sources
// of the instruction in ID.
//   clk, rst_n           : clock, asynchronous active-low reset
//   id_rs, id_rt         : ID source register indices
//   id_use_rs, id_use_rt : ID instruction really reads rs / rt
//   id_rd, id_we, id_load: ID destination, write enable, is-load
//   flush                : ID instruction is killed (taken branch/jump in EX)
//   hold                 : global freeze, all state holds
//   fwd_a_sel, fwd_b_sel : registered EX operand-mux selects
//   stall                : combinational, freeze PC and IF/ID
//   ex_bubble            : combinational, load a NOP into ID/EX this edge
// id_rd must be PIPE_REG_W wide; REG_W exists for port compatibility.
// ---------------------------------------------------------------------------
module fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_load,
    input  logic             flush,
    input  logic             hold,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall,
    output logic             ex_bubble
);

    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;
    stage_rec_t ex_d;

    logic       load_use;
    logic [1:0] sel_a_d;
    logic [1:0] sel_b_d;

    always_comb begin
        ex_d      = STAGE_EMPTY;
        ex_d.rd   = id_rd;
        ex_d.we   = id_we;
        ex_d.load = id_load;
    end

    // A load in EX only has data at the end of MEM, so a dependent ID
    // instruction waits one cycle and then picks it up from MEM-WB.
    assign load_use = ex_q.load &&
                      (src_hit(ex_q, id_rs, id_use_rs) ||
                       src_hit(ex_q, id_rt, id_use_rt));

    // Flush kills the dependent instruction, so it never needs to stall;
    // hold overrides both because nothing may move this edge.
    assign stall     = load_use && !flush && !hold;
    assign ex_bubble = (stall || flush) && !hold;

    assign sel_a_d = fwd_select(ex_q, mem_q, id_rs, id_use_rs);
    assign sel_b_d = fwd_select(ex_q, mem_q, id_rt, id_use_rt);

    fwd_track_stage u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!hold),
        .clr   (ex_bubble),
        .d     (ex_d),
        .q     (ex_q)
    );

    fwd_track_stage u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!hold),
        .clr   (1'b0),
        .d     (ex_q),
        .q     (mem_q)
    );

    // Kept for debug/assertions only: the register file is write-through,
    // so WB never needs a forwarding path.
    fwd_track_stage u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!hold),
        .clr   (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    // Selects are computed in ID and used for the whole EX cycle of the
    // same instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
        end else if (!hold) begin
            if (ex_bubble) begin
                fwd_a_sel <= '0;
                fwd_b_sel <= '0;
            end else begin
                fwd_a_sel <= SEL_W'(sel_a_d);
                fwd_b_sel <= SEL_W'(sel_b_d);
            end
        end
    end

    // The tracker advances as a shift register whenever hold is low.
    a_wb_follows_mem: assert property (
        @(posedge clk) disable iff (!rst_n)
        !hold |=> (wb_q == $past(mem_q))
    );

endmodule

// File: tb/tb_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_ctrl
// Directed scenarios from the pipeline's hazard cases plus a randomized run
// compared against an in-flight instruction model.
// ---------------------------------------------------------------------------
module tb_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_use_rs, id_use_rt, id_we, id_load;
    logic       flush, hold;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, ex_bubble;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    logic [4:0] m_rd [3];
    logic       m_we [3];
    logic       m_ld [3];
    logic [1:0] m_sel_a, m_sel_b;

    fwd_ctrl #(.REG_W(5), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_rd     (id_rd),
        .id_we     (id_we),
        .id_load   (id_load),
        .flush     (flush),
        .hold      (hold),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .stall     (stall),
        .ex_bubble (ex_bubble)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic m_writes(input int i, input logic [4:0] src);
        return m_we[i] && (m_rd[i] == src) && (src != 5'd0);
    endfunction

    function automatic logic m_stall();
        return !hold && !flush && m_ld[0] &&
               ((id_use_rs && m_writes(0, id_rs)) || (id_use_rt && m_writes(0, id_rt)));
    endfunction

    function automatic logic m_bubble();
        return !hold && (m_stall() || flush);
    endfunction

    // Search producers youngest first. A load found in EX cannot forward;
    // that instruction is always bubbled, so its select is 0.
    function automatic logic [1:0] m_src_sel(input logic u, input logic [4:0] src);
        if (!u) return 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (m_writes(i, src)) begin
                if (i == 0) return m_ld[0] ? 2'd0 : 2'd1;
                return 2'd2;
            end
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 5'd0; m_we[i] = 1'b0; m_ld[i] = 1'b0;
        end
        m_sel_a = 2'd0;
        m_sel_b = 2'd0;
    endtask

    task automatic model_edge();
        logic       b;
        logic [1:0] na, nb;
        b  = m_bubble();
        na = m_src_sel(id_use_rs, id_rs);
        nb = m_src_sel(id_use_rt, id_rt);
        if (!hold) begin
            for (int i = 2; i > 0; i--) begin
                m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1];
            end
            m_rd[0] = b ? 5'd0 : id_rd;
            m_we[0] = b ? 1'b0 : id_we;
            m_ld[0] = b ? 1'b0 : id_load;
            m_sel_a = b ? 2'd0 : na;
            m_sel_b = b ? 2'd0 : nb;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rd = rd; id_we = we; id_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        flush = 1'b0; hold = 1'b0;
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel_a: got %0d expected 0", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel_b: got %0d expected 0", fwd_b_sel); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got %0b expected 0", ex_bubble); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_back_to_back();
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub $4,$3,$5
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %0b expected 0", stall); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_sel_a: got %0d expected 1", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL b2b_sel_b: got %0d expected 0", fwd_b_sel); end
    endtask

    task automatic test_distance2();
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        tick();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);   // nop
        tick();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // or $6,$3,$3
        tick();
        n_checks++; if (fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL dist2_sel_a: got %0d expected 2", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL dist2_sel_b: got %0d expected 2", fwd_b_sel); end
    endtask

    task automatic test_load_use();
        drain();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7,0($1)
        tick();
        set_id(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // add $8,$7,$7
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b expected 1", stall); end
        n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %0b expected 1", ex_bubble); end
        tick();                                             // add held in ID
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %0b expected 0", stall); end
        n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_once: got %0b expected 0", ex_bubble); end
        n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL lu_bubble_sel: got %0d expected 0", fwd_a_sel); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL lu_sel_a: got %0d expected 2", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL lu_sel_b: got %0d expected 2", fwd_b_sel); end
    endtask

    task automatic test_zero_and_priority();
        drain();
        set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);   // addi $0,$0,5
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add $9,$0,$0
        tick();
        n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL zero_sel_a: got %0d expected 0", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL zero_sel_b: got %0d expected 0", fwd_b_sel); end
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3 again
        tick();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // use $3
        tick();
        n_checks++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL prio_sel_a: got %0d expected 1", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd1) begin n_fail++; $display("FAIL prio_sel_b: got %0d expected 1", fwd_b_sel); end
    endtask

    task automatic test_flush_load_use();
        drain();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7
        tick();
        set_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);   // dependent
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b expected 0", stall); end
        n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble: got %0b expected 1", ex_bubble); end
        tick();
        flush = 1'b0;
        #1;
        // ex was cleared, so the lw (now in MEM) cannot cause a stall.
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_ex_cleared: got %0b expected 0", stall); end
        n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL flush_sel: got %0d expected 0", fwd_a_sel); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL flush_after_sel: got %0d expected 2", fwd_a_sel); end
    endtask

    task automatic test_hold();
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub $4,$3,$5
        tick();
        set_id(5'd4, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // uses $4 and $3
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            #1;
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall: got %0b expected 0", stall); end
            n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL hold_bubble: got %0b expected 0", ex_bubble); end
            tick();
            n_checks++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL hold_sel_a: got %0d expected 1", fwd_a_sel); end
            n_checks++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL hold_sel_b: got %0d expected 0", fwd_b_sel); end
        end
        hold = 1'b0; flush = 1'b0;
        tick();
        n_checks++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL hold_resume_a: got %0d expected 1", fwd_a_sel); end
        n_checks++; if (fwd_b_sel !== 2'd2) begin n_fail++; $display("FAIL hold_resume_b: got %0d expected 2", fwd_b_sel); end
    endtask

    task automatic test_reset_mid();
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        tick();
        set_id(5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw $7,0($3)
        tick();
        set_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);   // dependent on $7
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_stall: got %0b expected 1", stall); end
        n_checks++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL rmid_pre_sel: got %0d expected 1", fwd_a_sel); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %0b expected 0", stall); end
        n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL rmid_bubble: got %0b expected 0", ex_bubble); end
        n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL rmid_sel_a: got %0d expected 0", fwd_a_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_discard_stall: got %0b expected 0", stall); end
        tick();
        n_checks++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL rmid_discard_sel: got %0d expected 0", fwd_a_sel); end
    endtask

    task automatic test_random();
        logic e_stall, e_bubble;
        logic held_id;
        held_id = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // IF/ID is frozen by stall, so keep the ID instruction then.
            if (!held_id) begin
                set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 2) == 0));
            end
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            #1;
            e_stall  = m_stall();
            e_bubble = m_bubble();
            n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %0b expected %0b", c, stall, e_stall); end
            n_checks++; if (ex_bubble !== e_bubble) begin n_fail++; $display("FAIL rnd_bubble c=%0d: got %0b expected %0b", c, ex_bubble, e_bubble); end
            held_id = e_stall || hold;
            tick();
            n_checks++; if (fwd_a_sel !== m_sel_a) begin n_fail++; $display("FAIL rnd_sel_a c=%0d: got %0d expected %0d", c, fwd_a_sel, m_sel_a); end
            n_checks++; if (fwd_b_sel !== m_sel_b) begin n_fail++; $display("FAIL rnd_sel_b c=%0d: got %0d expected %0d", c, fwd_b_sel, m_sel_b); end
        end
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_zero_and_priority();
        test_flush_load_use();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
